// File: rtl/sal_fifo_rd_adapter_if.sv
// Read-side bundle between SAL_FIFO, the pop adapter and the downstream consumer.
// master = adapter side, slave = FIFO/consumer side.
interface sal_fifo_rd_adapter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty_i;
    logic                  fifo_rden_o;
    logic [DATA_WIDTH-1:0] fifo_rdata_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [DATA_WIDTH-1:0] data_o;

    modport master (
        input  fifo_empty_i, fifo_rdata_i, ready_i,
        output fifo_rden_o, valid_o, data_o
    );

    modport slave (
        output fifo_empty_i, fifo_rdata_i, ready_i,
        input  fifo_rden_o, valid_o, data_o
    );
endinterface

// File: rtl/sal_fifo_rd_adapter.sv
// Pop stage for SAL_FIFO: head + skid buffer turning empty/rden/rdata into valid/ready.
// Optional statistics counters are built when SAL_FIFO_RD_ADAPTER_STATS_EN is defined.
module sal_fifo_rd_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sal_fifo_rd_adapter_if.master bus
`ifdef SAL_FIFO_RD_ADAPTER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] xfer_cnt_o,
    output logic [STAT_WIDTH-1:0] stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t                  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  pop;
    logic                  valid;
    logic                  xfer;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The pop decision depends only on FIFO state and local occupancy, never on ready_i.
    assign pop   = rst_n & ~bus.fifo_empty_i & (cnt_q != TWO);
    assign valid = (cnt_q != EMPTY);
    assign xfer  = valid & bus.ready_i;

    assign bus.fifo_rden_o = pop;
    assign bus.valid_o     = valid;
    assign bus.data_o      = head_q;

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        skid_d = skid_q;
        case (cnt_q)
            EMPTY: begin
                if (pop) begin
                    cnt_d  = ONE;
                    head_d = bus.fifo_rdata_i;
                end
            end
            ONE: begin
                if (pop && xfer) begin
                    head_d = bus.fifo_rdata_i;
                end else if (pop) begin
                    cnt_d  = TWO;
                    skid_d = bus.fifo_rdata_i;
                end else if (xfer) begin
                    cnt_d = EMPTY;
                end
            end
            TWO: begin
                if (xfer) begin
                    cnt_d  = ONE;
                    head_d = skid_q;
                end
            end
            default: cnt_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= EMPTY;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

`ifdef SAL_FIFO_RD_ADAPTER_STATS_EN
    logic [STAT_WIDTH-1:0] xfer_cnt_q;
    logic [STAT_WIDTH-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (xfer) begin
                xfer_cnt_q <= sat_inc(xfer_cnt_q);
            end
            if (valid && !bus.ready_i) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

    assign xfer_cnt_o  = xfer_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
`endif

endmodule

// File: tb/tb_sal_fifo_rd_adapter.sv
// Directed and randomized bench for sal_fifo_rd_adapter with a queue-based FIFO
// and an occupancy/ordering reference model.
module tb_sal_fifo_rd_adapter;
    localparam int DW = 32;
    localparam int SW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sal_fifo_rd_adapter_if #(.DATA_WIDTH(DW)) bus ();

`ifdef SAL_FIFO_RD_ADAPTER_STATS_EN
    logic [SW-1:0] xfer_cnt;
    logic [SW-1:0] stall_cnt;
`endif

    sal_fifo_rd_adapter #(
        .DATA_WIDTH(DW),
        .STAT_WIDTH(SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SAL_FIFO_RD_ADAPTER_STATS_EN
        ,
        .xfer_cnt_o (xfer_cnt),
        .stall_cnt_o(stall_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] fifo_q[$];   // upstream FIFO contents
    logic [DW-1:0] buf_q[$];    // words the adapter should be holding, oldest first
    logic [DW-1:0] got_q[$];    // words actually accepted from the DUT
    logic [DW-1:0] exp5_q[$];

    logic        ready;
    logic        rst_drv;
    bit          was_reset;
    int unsigned m_xfer, m_stall;
    int          stall_seen;
    int          rden_seen;
    int          valid_seen;
    logic        obs_rden, obs_valid;
    logic [DW-1:0] obs_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v);
        return (v == (1 << SW) - 1) ? v : v + 1;
    endfunction

    // One clock cycle: drive at negedge, check the settled outputs, advance the model.
    task automatic cyc();
        logic exp_valid, exp_rden;
        @(negedge clk);
        rst_n            = rst_drv;
        bus.ready_i      = ready;
        bus.fifo_empty_i = (fifo_q.size() == 0);
        bus.fifo_rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
        #1;
        exp_valid = (buf_q.size() != 0);
        exp_rden  = rst_n && (fifo_q.size() != 0) && (buf_q.size() < 2);
        obs_rden  = bus.fifo_rden_o;
        obs_valid = bus.valid_o;
        obs_data  = bus.data_o;
        check("valid", obs_valid, exp_valid);
        check("rden", obs_rden, exp_rden);
        if (was_reset) check("data_rst", obs_data, 0);
        else if (exp_valid) check("data", obs_data, buf_q[0]);
`ifdef SAL_FIFO_RD_ADAPTER_STATS_EN
        check("xfer_cnt", xfer_cnt, m_xfer);
        check("stall_cnt", stall_cnt, m_stall);
`endif
        if (obs_rden) rden_seen++;
        if (obs_valid) valid_seen++;
        if (obs_valid && !ready && rst_n) stall_seen++;
        if (obs_valid && ready && rst_n) got_q.push_back(obs_data);
        was_reset = 0;
        if (!rst_n) begin
            buf_q.delete();
            m_xfer    = 0;
            m_stall   = 0;
            was_reset = 1;
        end else begin
            if (exp_valid && ready) begin
                void'(buf_q.pop_front());
                m_xfer = sat(m_xfer);
            end
            if (exp_valid && !ready) m_stall = sat(m_stall);
            if (exp_rden) buf_q.push_back(fifo_q.pop_front());
        end
    endtask

    initial begin
        int cycles;
        bit tog;
        logic [DW-1:0] w;

        rst_n = 1'b0; rst_drv = 1'b0; ready = 1'b0;
        bus.ready_i = 1'b0; bus.fifo_empty_i = 1'b1; bus.fifo_rdata_i = '0;
        was_reset = 1; m_xfer = 0; m_stall = 0;
        @(posedge clk);

        // 1: reset held with a non-empty FIFO
        fifo_q.push_back(32'h1234_5678);
        cyc(); cyc();
        check("t1_rden", obs_rden, 0);
        check("t1_valid", obs_valid, 0);
        check("t1_data", obs_data, 0);
        fifo_q.delete();
        rst_drv = 1'b1;

        // 2: single word latency
        fifo_q.push_back(32'hA5A5_0001);
        ready = 1'b1;
        cyc();
        check("t2_rden_n", obs_rden, 1);
        check("t2_valid_n", obs_valid, 0);
        cyc();
        check("t2_valid_n1", obs_valid, 1);
        check("t2_data_n1", obs_data, 32'hA5A5_0001);
        cyc();
        check("t2_valid_n2", obs_valid, 0);

        // 3: 16 back-to-back words
        got_q.delete(); valid_seen = 0;
        for (int i = 0; i < 16; i++) fifo_q.push_back(i);
        for (int i = 0; i < 18; i++) cyc();
        check("t3_valid_cycles", valid_seen, 16);
        check("t3_count", got_q.size(), 16);
        for (int i = 0; i < 16 && i < got_q.size(); i++) check("t3_order", got_q[i], i);

        // 4: backpressure fills head + skid, then drains in order
        got_q.delete(); rden_seen = 0; valid_seen = 0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(i);
        ready = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        check("t4_pops", rden_seen, 2);
        check("t4_rden_held", obs_rden, 0);
        check("t4_data_held", obs_data, 0);
        ready = 1'b1; valid_seen = 0;
        for (int i = 0; i < 6; i++) cyc();
        check("t4_valid_cycles", valid_seen, 4);
        check("t4_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("t4_order", got_q[i], i);

        // 5: random fill with alternating ready
        rst_drv = 1'b0; cyc(); fifo_q.delete(); rst_drv = 1'b1;
        got_q.delete(); exp5_q.delete(); stall_seen = 0; tog = 1'b1; cycles = 0;
        while (got_q.size() < 200 && cycles < 3000) begin
            if (exp5_q.size() < 200 && $urandom_range(0, 3) != 0) begin
                w = $urandom;
                fifo_q.push_back(w);
                exp5_q.push_back(w);
            end
            ready = tog;
            tog = ~tog;
            cyc();
            cycles++;
        end
        check("t5_count", got_q.size(), 200);
        for (int i = 0; i < 200 && i < got_q.size(); i++) check("t5_order", got_q[i], exp5_q[i]);
`ifdef SAL_FIFO_RD_ADAPTER_STATS_EN
        cyc();
        check("t5_xfer_cnt", xfer_cnt, 200);
        check("t5_stall_cnt", stall_cnt, stall_seen);
`endif

        // 6: reset while both buffer slots are occupied
        ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'h5000 + i);
        for (int i = 0; i < 3; i++) cyc();
        check("t6_full_valid", obs_valid, 1);
        check("t6_full_rden", obs_rden, 0);
        rst_drv = 1'b0; cyc(); fifo_q.delete(); rst_drv = 1'b1;
        cyc();
        check("t6_valid", obs_valid, 0);
        check("t6_data", obs_data, 0);
`ifdef SAL_FIFO_RD_ADAPTER_STATS_EN
        check("t6_xfer_cnt", xfer_cnt, 0);
        check("t6_stall_cnt", stall_cnt, 0);
`endif
        got_q.delete(); ready = 1'b1;
        for (int i = 0; i < 3; i++) fifo_q.push_back(32'h100 + i);
        for (int i = 0; i < 6; i++) cyc();
        check("t6_count", got_q.size(), 3);
        for (int i = 0; i < 3 && i < got_q.size(); i++) check("t6_order", got_q[i], 32'h100 + i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
